// File: rtl/cdc_clear_ctrl_if.sv
// Handshake bundle between the upstream producer, the clear sequencer and
// the CDC source port. The sequencer connects through the slave modport;
// the master modport is the environment side (producer + CDC source).
interface cdc_clear_ctrl_if;
  logic up_valid_i;
  logic up_ready_o;
  logic cdc_valid_o;
  logic cdc_ready_i;
  logic cdc_clear_o;
  logic cdc_clear_pending_i;

  modport master (
    output up_valid_i,
    output cdc_ready_i,
    output cdc_clear_pending_i,
    input  up_ready_o,
    input  cdc_valid_o,
    input  cdc_clear_o
  );

  modport slave (
    input  up_valid_i,
    input  cdc_ready_i,
    input  cdc_clear_pending_i,
    output up_ready_o,
    output cdc_valid_o,
    output cdc_clear_o
  );
endinterface

// File: rtl/cdc_clear_ctrl.sv
// Source-side clear sequencer for a clearable 2-phase CDC.
// Passes valid/ready straight through while idle, and turns a one-cycle
// clear request into: drain (or abort) the stalled beat, pulse clear,
// wait for the CDC clear_pending round trip, then acknowledge.
// Data never passes through this block; only the handshake is gated.
// Optional feature: define CDC_CLEAR_CTRL_TIMEOUT_EN to bound the DRAIN
// phase to DRAIN_TIMEOUT cycles, dropping the stalled beat via abort_o.
module cdc_clear_ctrl #(
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
  parameter int DRAIN_TIMEOUT = 64,
`endif
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_req_i,
  output logic                 clear_ack_o,
  output logic                 busy_o,
  output logic                 abort_o,
  output logic [CNT_WIDTH-1:0] clear_count_o,
  cdc_clear_ctrl_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR,
    S_WAIT_PEND,
    S_WAIT_REL,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_reqPend;
  logic                 r_remote;
  logic                 w_remoteNext;
  logic                 w_enterClear;
  logic                 w_timeout;
  logic [CNT_WIDTH-1:0] r_count;

`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  logic [DW-1:0] r_drainCnt;

  // Drain cycle counter: 0 on the first DRAIN cycle, reset whenever DRAIN is left.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drainCnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_drainCnt <= r_drainCnt + 1'b1;
    end else begin
      r_drainCnt <= '0;
    end
  end

  // Give up on the stalled beat on the last allowed DRAIN cycle with no handshake.
  always_comb begin
    w_timeout = (r_state == S_DRAIN) && (r_drainCnt == DW'(DRAIN_TIMEOUT - 1)) &&
                !bus.cdc_clear_pending_i && bus.up_valid_i && !bus.cdc_ready_i;
  end
`else
  // Without the timeout the drain waits for as long as the beat stays stalled.
  always_comb begin
    w_timeout = 1'b0;
  end
`endif

  // State, remote-clear flag and coalesced request register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_remote  <= 1'b0;
      r_reqPend <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_remote <= w_remoteNext;
      if (w_enterClear) begin
        r_reqPend <= 1'b0;
      end else if (clear_req_i) begin
        r_reqPend <= 1'b1;
      end
    end
  end

  // Completed local clear counter, sticking at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if ((r_state == S_DONE) && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Next-state and handshake gating; a remote clear always wins over a local one.
  always_comb begin
    w_nextState     = r_state;
    w_remoteNext    = r_remote;
    w_enterClear    = 1'b0;
    bus.cdc_valid_o = 1'b0;
    bus.up_ready_o  = 1'b0;
    bus.cdc_clear_o = 1'b0;
    clear_ack_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cdc_valid_o = bus.up_valid_i;
        bus.up_ready_o  = bus.cdc_ready_i;
        if (bus.cdc_clear_pending_i) begin
          w_nextState  = S_WAIT_REL;
          w_remoteNext = 1'b1;
        end else if (clear_req_i || r_reqPend) begin
          w_enterClear = 1'b1;
          if (bus.up_valid_i && !bus.cdc_ready_i) begin
            w_nextState = S_DRAIN;
          end else begin
            w_nextState = S_CLEAR;
          end
        end
      end
      S_DRAIN: begin
        bus.cdc_valid_o = bus.up_valid_i;
        bus.up_ready_o  = bus.cdc_ready_i;
        if (bus.cdc_clear_pending_i) begin
          w_nextState = S_WAIT_REL;
        end else if (!bus.up_valid_i || bus.cdc_ready_i || w_timeout) begin
          w_nextState  = S_CLEAR;
          w_enterClear = 1'b1;
        end
      end
      S_CLEAR: begin
        bus.cdc_clear_o = 1'b1;
        w_nextState     = S_WAIT_PEND;
      end
      S_WAIT_PEND: begin
        if (bus.cdc_clear_pending_i) begin
          w_nextState = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!bus.cdc_clear_pending_i) begin
          if (r_remote) begin
            w_nextState  = S_IDLE;
            w_remoteNext = 1'b0;
          end else begin
            w_nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        clear_ack_o = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Status outputs.
  always_comb begin
    busy_o        = (r_state != S_IDLE);
    abort_o       = w_timeout;
    clear_count_o = r_count;
  end

endmodule

// File: tb/tb_cdc_clear_ctrl.sv
// Randomized scoreboard bench for cdc_clear_ctrl.
// Stimulus plans whole clear episodes ahead of time from timing rules,
// pushing expected pulses (clear / abort / ack with their cycle) into a
// queue and per-cycle expectations into maps; a negedge monitor compares.
// Define CDC_CLEAR_CTRL_TIMEOUT_EN to also exercise the drain timeout.
module tb_cdc_clear_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TO      = 4;
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
  localparam int MAXSTALL = TO;
`else
  localparam int MAXSTALL = 6;
`endif

  localparam logic [2:0] EV_CLR = 3'b001;
  localparam logic [2:0] EV_ACK = 3'b010;
  localparam logic [2:0] EV_ABT = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } ev_t;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             clearReq = 1'b0;
  logic             clearAck;
  logic             busy;
  logic             abortP;
  logic [CNT_W-1:0] clearCount;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  beatCnt = 0;
  int  expCnt = 0;
  bit  monEn = 1'b0;
  ev_t evQ[$];
  ev_t monEv;

  int expMode[int];
  bit expBusy[int];
  int expCount[int];
  bit sReq[int];
  bit sVal[int];
  bit sRdy[int];
  bit sPend[int];

  cdc_clear_ctrl_if bus();

  cdc_clear_ctrl #(
`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
    .DRAIN_TIMEOUT(TO),
`endif
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .clear_req_i  (clearReq),
    .clear_ack_o  (clearAck),
    .busy_o       (busy),
    .abort_o      (abortP),
    .clear_count_o(clearCount),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void pushEv(input logic [2:0] kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    evQ.push_back(e);
  endfunction

  // Monitor: pulses against the queue, gating/passthrough, busy and count per cycle.
  always @(negedge clk) begin
    if (rstN && monEn) begin
      if (bus.up_valid_i && bus.up_ready_o) beatCnt++;
      while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
        monEv = evQ.pop_front();
        checkOutput("missed_pulse", 0, int'(monEv.kind));
      end
      if (bus.cdc_clear_o || clearAck || abortP) begin
        if (evQ.size() == 0) begin
          checkOutput("unexpected_pulse", int'({abortP, clearAck, bus.cdc_clear_o}), 0);
        end else begin
          monEv = evQ.pop_front();
          checkOutput("pulse_kind", int'({abortP, clearAck, bus.cdc_clear_o}), int'(monEv.kind));
          checkOutput("pulse_cycle", cyc, monEv.cyc);
        end
      end
      if (expMode.exists(cyc)) begin
        if (expMode[cyc] == 1)
          checkOutput("passthrough", int'({bus.cdc_valid_o, bus.up_ready_o}),
                      int'({bus.up_valid_i, bus.cdc_ready_i}));
        else
          checkOutput("gated", int'({bus.cdc_valid_o, bus.up_ready_o}), 0);
      end
      if (expBusy.exists(cyc)) checkOutput("busy", int'(busy), int'(expBusy[cyc]));
      if (expCount.exists(cyc)) checkOutput("count", int'(clearCount), expCount[cyc]);
    end
  end

  // Drive the planned inputs cycle by cycle; unplanned cycles are idle random traffic.
  task automatic applyStimulus(input int endCyc);
    while (cyc <= endCyc) begin
      clearReq                  = sReq.exists(cyc);
      bus.cdc_clear_pending_i   = sPend.exists(cyc);
      bus.up_valid_i            = sVal.exists(cyc) ? sVal[cyc] : 1'($urandom_range(0, 1));
      bus.cdc_ready_i           = sRdy.exists(cyc) ? sRdy[cyc] : 1'($urandom_range(0, 1));
      if (!expMode.exists(cyc)) begin
        expMode[cyc] = 1;
        expBusy[cyc] = 1'b0;
      end
      stepCycle();
    end
  endtask

  // Plan the clear pulse at cycle c and the pending round trip that follows it.
  task automatic planClear(input int c, input int d, input int h, output int a);
    a = c + 1 + d + h;
    pushEv(EV_CLR, c);
    for (int x = c; x <= a; x++) begin
      expMode[x] = 2;
      expBusy[x] = 1'b1;
      sVal[x]    = 1'($urandom_range(0, 1));
      sRdy[x]    = 1'($urandom_range(0, 1));
    end
    for (int x = c + d; x < c + d + h; x++) sPend[x] = 1'b1;
    pushEv(EV_ACK, a);
    if (expCnt < CNT_MAX) expCnt++;
    expCount[a + 1] = expCnt;
  endtask

  // Plan a local clear requested at cycle k, optionally behind a stalled beat.
  task automatic planLocal(input int k, input int stall, input bit tmo, input int d,
                           input int h, input int extra, output int last);
    int c;
    int a;
    int n;
    sReq[k]    = 1'b1;
    expMode[k] = 1;
    expBusy[k] = 1'b0;
    if (stall == 0 && !tmo) begin
      sVal[k] = 1'($urandom_range(0, 1));
      sRdy[k] = sVal[k] ? 1'b1 : 1'($urandom_range(0, 1));
      c = k + 1;
    end else begin
      n = tmo ? TO : stall;
      sVal[k] = 1'b1;
      sRdy[k] = 1'b0;
      for (int i = 1; i <= n; i++) begin
        sVal[k + i]    = 1'b1;
        sRdy[k + i]    = !tmo && (i == n);
        expMode[k + i] = 1;
        expBusy[k + i] = 1'b1;
      end
      if (tmo) pushEv(EV_ABT, k + n);
      c = k + n + 1;
    end
    planClear(c, d, h, a);
    for (int i = 0; i < extra; i++) sReq[c + i] = 1'b1;
    if (extra > 0) begin
      sVal[a + 1]    = 1'b0;
      sRdy[a + 1]    = 1'($urandom_range(0, 1));
      expMode[a + 1] = 1;
      expBusy[a + 1] = 1'b0;
      planClear(a + 2, d, h, a);
    end
    last = a;
  endtask

  // Plan a remote clear: pending held for h cycles starting at k.
  task automatic planRemote(input int k, input int h, output int last);
    expMode[k] = 1;
    expBusy[k] = 1'b0;
    for (int x = k; x < k + h; x++) sPend[x] = 1'b1;
    for (int x = k + 1; x <= k + h; x++) begin
      expMode[x] = 2;
      expBusy[x] = 1'b1;
    end
    expCount[k + h + 2] = expCnt;
    last = k + h + 2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last;
    int b0;
    bus.up_valid_i          = 1'b0;
    bus.cdc_ready_i         = 1'b0;
    bus.cdc_clear_pending_i = 1'b0;
    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ack", int'(clearAck), 0);
    checkOutput("reset_abort", int'(abortP), 0);
    checkOutput("reset_clear", int'(bus.cdc_clear_o), 0);
    checkOutput("reset_count", int'(clearCount), 0);
    checkOutput("reset_valid", int'(bus.cdc_valid_o), 0);
    checkOutput("reset_ready", int'(bus.up_ready_o), 0);
    stepCycle();
    rstN  = 1'b1;
    monEn = 1'b1;
    applyStimulus(cyc + 1);

    $display("[TB] idle passthrough");
    for (int i = 0; i < 10; i++) begin
      sVal[cyc + i] = 1'b1;
      sRdy[cyc + i] = 1'b1;
    end
    b0 = beatCnt;
    applyStimulus(cyc + 9);
    checkOutput("idle_beats", beatCnt - b0, 10);
    applyStimulus(cyc + 19);

    $display("[TB] clean clears (count saturates)");
    for (int i = 0; i < 5; i++) begin
      planLocal(cyc, 0, 1'b0, $urandom_range(1, 4), $urandom_range(1, 4), 0, last);
      applyStimulus(last + 2);
    end

    $display("[TB] drain");
    for (int i = 0; i < 4; i++) begin
      int s;
      s  = (i == 0) ? ((MAXSTALL < 5) ? MAXSTALL : 5) : $urandom_range(1, MAXSTALL);
      planLocal(cyc, s, 1'b0, $urandom_range(1, 3), $urandom_range(1, 3), 0, last);
      b0 = beatCnt;
      applyStimulus(last);
      checkOutput("drain_beats", beatCnt - b0, 1);
      applyStimulus(cyc + 2);
    end

`ifdef CDC_CLEAR_CTRL_TIMEOUT_EN
    $display("[TB] drain timeout");
    for (int i = 0; i < 2; i++) begin
      planLocal(cyc, 0, 1'b1, $urandom_range(1, 3), $urandom_range(1, 3), 0, last);
      b0 = beatCnt;
      applyStimulus(last);
      checkOutput("timeout_beats", beatCnt - b0, 0);
      applyStimulus(cyc + 2);
    end
`endif

    $display("[TB] remote clear");
    planRemote(cyc, 6, last);
    applyStimulus(last);
    for (int i = 0; i < 2; i++) begin
      planRemote(cyc, $urandom_range(1, 5), last);
      applyStimulus(last + 1);
    end

    $display("[TB] coalesced requests");
    planLocal(cyc, 0, 1'b0, 2, 2, 3, last);
    applyStimulus(last + 3);

    $display("[TB] reset during WAIT_PEND");
    sReq[cyc]    = 1'b1;
    sVal[cyc]    = 1'b0;
    sRdy[cyc]    = 1'b0;
    expMode[cyc] = 1;
    expBusy[cyc] = 1'b0;
    pushEv(EV_CLR, cyc + 1);
    for (int x = cyc + 1; x <= cyc + 3; x++) begin
      expMode[x] = 2;
      expBusy[x] = 1'b1;
    end
    applyStimulus(cyc + 3);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_count", int'(clearCount), 0);
    expCnt = 0;
    stepCycle();
    rstN = 1'b1;
    expCount[cyc + 3] = 0;
    applyStimulus(cyc + 6);
    planLocal(cyc, 0, 1'b0, 1, 1, 0, last);
    applyStimulus(last + 3);

    checkOutput("events_left", evQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
